// File: rtl/pipe_pkg.sv
// Shared pipeline encodings: writeback source select, load type, default widths.
// No logic; constants only.
// Imported by the MEM/WB stage and the load extender.
package pipe_pkg;

   localparam int DEF_DATA_W = 32;
   localparam int DEF_REG_AW = 5;

   // Writeback source select (2'b11 is reserved)
   localparam logic [1:0] WB_SEL_ALU  = 2'b00;
   localparam logic [1:0] WB_SEL_LOAD = 2'b01;
   localparam logic [1:0] WB_SEL_LINK = 2'b10;

   // Load type (3'b101..3'b111 are reserved)
   localparam logic [2:0] LD_LW  = 3'b000;
   localparam logic [2:0] LD_LH  = 3'b001;
   localparam logic [2:0] LD_LHU = 3'b010;
   localparam logic [2:0] LD_LB  = 3'b011;
   localparam logic [2:0] LD_LBU = 3'b100;

endpackage

// File: rtl/load_extend.sv
// Load extractor: picks byte/halfword/word from an aligned little-endian word and extends it.
// Latency: purely combinational.
// Backpressure: none; flags misalignment and unknown load types for the caller to act on.
module load_extend
   import pipe_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic [DATA_W-1:0] RdWord,
   input  logic [1:0]        Offset,
   input  logic [2:0]        LoadType,
   output logic [DATA_W-1:0] ExtData,
   output logic              Misalign,
   output logic              TypeOk
);

   logic [7:0]  byteSel;
   logic [15:0] halfSel;

   // Byte lane at Offset*8, halfword lane at Offset[1]*16
   assign byteSel = RdWord[{Offset, 3'b000} +: 8];
   assign halfSel = RdWord[{Offset[1], 4'b0000} +: 16];

   // Extend the selected lane; reserved types pass zero and are flagged
   always_comb begin
      ExtData  = '0;
      Misalign = 1'b0;
      TypeOk   = 1'b1;
      case (LoadType)
         LD_LW: begin
            ExtData  = RdWord;
            Misalign = (Offset != 2'b00);
         end
         LD_LH: begin
            ExtData  = {{(DATA_W-16){halfSel[15]}}, halfSel};
            Misalign = Offset[0];
         end
         LD_LHU: begin
            ExtData  = {{(DATA_W-16){1'b0}}, halfSel};
            Misalign = Offset[0];
         end
         LD_LB:   ExtData = {{(DATA_W-8){byteSel[7]}}, byteSel};
         LD_LBU:  ExtData = {{(DATA_W-8){1'b0}}, byteSel};
         default: TypeOk  = 1'b0;
      endcase
   end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with writeback select, load extension and retire counting.
// Latency: one cycle; inputs captured at edge N drive the register-file write port until edge N+1.
// Backpressure: Stall holds contents and masks the write; Flush (beats Stall) inserts a bubble. Optional MEM_WB_FWD_EN adds forwarding outputs.
module mem_wb_stage
   import pipe_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int REG_AW = DEF_REG_AW
) (
   input  logic              Clk,
   input  logic              Rst_n,
   input  logic              Stall,
   input  logic              Flush,
   input  logic              MemValid,
   input  logic              MemRegWrite,
   input  logic [1:0]        MemWbSel,
   input  logic [2:0]        MemLoadType,
   input  logic [DATA_W-1:0] MemAluResult,
   input  logic [DATA_W-1:0] MemReadData,
   input  logic [DATA_W-1:0] MemPcPlus4,
   input  logic [REG_AW-1:0] MemWriteReg,
   output logic [REG_AW-1:0] WriteRegister,
   output logic [DATA_W-1:0] WriteData,
   output logic              RegWrite,
   output logic              MisalignErr,
`ifdef MEM_WB_FWD_EN
   output logic              FwdValid,
   output logic [REG_AW-1:0] FwdReg,
   output logic [DATA_W-1:0] FwdData,
`endif
   output logic [31:0]       RetireCount
);

   logic              validQ;
   logic              firstQ;      // instruction is in its first WB cycle
   logic              regWriteQ;
   logic [1:0]        wbSelQ;
   logic [2:0]        loadTypeQ;
   logic [DATA_W-1:0] aluQ;
   logic [DATA_W-1:0] rdQ;
   logic [DATA_W-1:0] pc4Q;
   logic [REG_AW-1:0] writeRegQ;
   logic [31:0]       retireCountQ;

   logic [DATA_W-1:0] loadData;
   logic              loadMisalign;
   logic              loadTypeOk;
   logic              isLoad;
   logic              misalign;
   logic              writeOk;

   // Pipeline register: flush clears valid, stall holds, otherwise capture MEM
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         validQ    <= 1'b0;
         firstQ    <= 1'b0;
         regWriteQ <= 1'b0;
         wbSelQ    <= '0;
         loadTypeQ <= '0;
         aluQ      <= '0;
         rdQ       <= '0;
         pc4Q      <= '0;
         writeRegQ <= '0;
      end else if (Flush) begin
         validQ <= 1'b0;
         firstQ <= 1'b0;
      end else if (!Stall) begin
         validQ    <= MemValid;
         firstQ    <= MemValid;
         regWriteQ <= MemRegWrite;
         wbSelQ    <= MemWbSel;
         loadTypeQ <= MemLoadType;
         aluQ      <= MemAluResult;
         rdQ       <= MemReadData;
         pc4Q      <= MemPcPlus4;
         writeRegQ <= MemWriteReg;
      end else begin
         // held instruction is no longer new, so the misalign pulse is not repeated
         firstQ <= 1'b0;
      end
   end

   // Retire counter: an instruction retires when it leaves WB unstalled
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         retireCountQ <= '0;
      end else if (validQ && !Stall) begin
         retireCountQ <= retireCountQ + 32'd1;
      end
   end

   load_extend #(
      .DATA_W(DATA_W)
   ) uLoadExtend (
      .RdWord  (rdQ),
      .Offset  (aluQ[1:0]),
      .LoadType(loadTypeQ),
      .ExtData (loadData),
      .Misalign(loadMisalign),
      .TypeOk  (loadTypeOk)
   );

   // Writeback data select and write qualification
   always_comb begin
      isLoad    = (wbSelQ == WB_SEL_LOAD);
      misalign  = isLoad && loadMisalign;
      WriteData = aluQ;
      writeOk   = validQ && regWriteQ && (writeRegQ != '0) && !misalign;
      case (wbSelQ)
         WB_SEL_ALU:  WriteData = aluQ;
         WB_SEL_LINK: WriteData = pc4Q;
         WB_SEL_LOAD: begin
            if (loadTypeOk) begin
               WriteData = loadData;
            end else begin
               writeOk = 1'b0;
            end
         end
         default:     writeOk = 1'b0;
      endcase
   end

   assign RegWrite      = writeOk && !Stall;
   assign MisalignErr   = validQ && firstQ && misalign;
   assign WriteRegister = validQ ? writeRegQ : '0;
   assign RetireCount   = retireCountQ;

`ifdef MEM_WB_FWD_EN
   // Forwarding sees the pending write even while the stage is held
   assign FwdValid = writeOk;
   assign FwdReg   = WriteRegister;
   assign FwdData  = WriteData;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Testbench for mem_wb_stage: directed test-plan scenarios plus randomized traffic against a reference model.
// Inputs change 1ns after the rising edge; outputs are sampled 2ns after it.
// Summary line reports check and error counts.
module tb_mem_wb_stage;

   logic        Clk;
   logic        Rst_n;
   logic        Stall;
   logic        Flush;
   logic        MemValid;
   logic        MemRegWrite;
   logic [1:0]  MemWbSel;
   logic [2:0]  MemLoadType;
   logic [31:0] MemAluResult;
   logic [31:0] MemReadData;
   logic [31:0] MemPcPlus4;
   logic [4:0]  MemWriteReg;
   logic [4:0]  WriteRegister;
   logic [31:0] WriteData;
   logic        RegWrite;
   logic        MisalignErr;
   logic [31:0] RetireCount;
`ifdef MEM_WB_FWD_EN
   logic        FwdValid;
   logic [4:0]  FwdReg;
   logic [31:0] FwdData;
`endif

   int checks = 0;
   int errors = 0;

   mem_wb_stage dut (
      .Clk          (Clk),
      .Rst_n        (Rst_n),
      .Stall        (Stall),
      .Flush        (Flush),
      .MemValid     (MemValid),
      .MemRegWrite  (MemRegWrite),
      .MemWbSel     (MemWbSel),
      .MemLoadType  (MemLoadType),
      .MemAluResult (MemAluResult),
      .MemReadData  (MemReadData),
      .MemPcPlus4   (MemPcPlus4),
      .MemWriteReg  (MemWriteReg),
      .WriteRegister(WriteRegister),
      .WriteData    (WriteData),
      .RegWrite     (RegWrite),
      .MisalignErr  (MisalignErr),
`ifdef MEM_WB_FWD_EN
      .FwdValid     (FwdValid),
      .FwdReg       (FwdReg),
      .FwdData      (FwdData),
`endif
      .RetireCount  (RetireCount)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // ---------------- reference model ----------------
   typedef struct packed {
      logic        valid;
      logic        first;
      logic        rw;
      logic [1:0]  sel;
      logic [2:0]  lt;
      logic [31:0] alu;
      logic [31:0] rd;
      logic [31:0] pc4;
      logic [4:0]  wr;
   } wb_t;

   wb_t         m;
   int unsigned mCount;

   task automatic model_reset();
      m      = '0;
      mCount = 0;
   endtask

   task automatic model_edge();
      if (!Rst_n) begin
         model_reset();
      end else begin
         if (m.valid && !Stall) mCount = mCount + 1;
         if (Flush) begin
            m.valid = 1'b0;
            m.first = 1'b0;
         end else if (!Stall) begin
            m = '{valid: MemValid, first: MemValid, rw: MemRegWrite, sel: MemWbSel,
                  lt: MemLoadType, alu: MemAluResult, rd: MemReadData,
                  pc4: MemPcPlus4, wr: MemWriteReg};
         end else begin
            m.first = 1'b0;
         end
      end
   endtask

   // Expected port values from the instruction held in the model
   function automatic void model_out(output logic eRw, output logic eFwd,
                                     output logic [4:0] eReg, output logic [31:0] eData,
                                     output logic eMis);
      int unsigned off;
      logic [31:0] b;
      logic [31:0] h;
      logic        mis;
      logic        ok;
      off   = int'(m.alu[1:0]);
      b     = (m.rd >> (8 * off)) & 32'hFF;
      h     = (m.rd >> (16 * (off / 2))) & 32'hFFFF;
      mis   = 1'b0;
      ok    = 1'b1;
      eData = m.alu;
      if (m.sel == 2'd2) begin
         eData = m.pc4;
      end else if (m.sel == 2'd3) begin
         ok = 1'b0;
      end else if (m.sel == 2'd1) begin
         case (m.lt)
            3'd0: begin eData = m.rd; mis = (off != 0); end
            3'd1: begin eData = (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h; mis = (off % 2 == 1); end
            3'd2: begin eData = h; mis = (off % 2 == 1); end
            3'd3: eData = (b >= 32'h80) ? (b | 32'hFFFF_FF00) : b;
            3'd4: eData = b;
            default: ok = 1'b0;
         endcase
      end
      eFwd = m.valid && m.rw && (m.wr != 5'd0) && !mis && ok;
      eRw  = eFwd && !Stall;
      eReg = m.valid ? m.wr : 5'd0;
      eMis = m.valid && m.first && mis;
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic drive_instr(input logic v, input logic rw, input logic [1:0] sel,
                              input logic [2:0] lt, input logic [31:0] alu,
                              input logic [31:0] rd, input logic [31:0] pc4,
                              input logic [4:0] wr);
      MemValid     = v;
      MemRegWrite  = rw;
      MemWbSel     = sel;
      MemLoadType  = lt;
      MemAluResult = alu;
      MemReadData  = rd;
      MemPcPlus4   = pc4;
      MemWriteReg  = wr;
   endtask

   task automatic drive_idle();
      drive_instr(1'b0, 1'b0, 2'd0, 3'd0, 32'h0, 32'h0, 32'h0, 5'd0);
      Stall = 1'b0;
      Flush = 1'b0;
   endtask

   task automatic step();
      @(posedge Clk);
      model_edge();
      #1;
   endtask

   task automatic apply_reset();
      drive_idle();
      Rst_n = 1'b0;
      model_reset();
      step();
      step();
      Rst_n = 1'b1;
      step();
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      drive_idle();
      Rst_n = 1'b0;
      model_reset();
      step();
      checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL reset_regwrite: got %b expected 0", RegWrite); end
      checks++; if (WriteRegister !== 5'd0) begin errors++; $display("FAIL reset_wreg: got %0d expected 0", WriteRegister); end
      checks++; if (WriteData !== 32'h0) begin errors++; $display("FAIL reset_wdata: got %h expected 0", WriteData); end
      checks++; if (MisalignErr !== 1'b0) begin errors++; $display("FAIL reset_mis: got %b expected 0", MisalignErr); end
      checks++; if (RetireCount !== 32'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", RetireCount); end
      Rst_n = 1'b1;
      step();
      // valid lw to r5 latched, then reset drops between edges
      drive_instr(1'b1, 1'b1, 2'd1, 3'd0, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0, 5'd5);
      step();
      drive_idle();
      #1;
      checks++; if (RegWrite !== 1'b1) begin errors++; $display("FAIL pre_reset_write: got %b expected 1", RegWrite); end
      Rst_n = 1'b0;
      model_reset();
      #1;
      checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL midreset_regwrite: got %b expected 0", RegWrite); end
      checks++; if (WriteRegister !== 5'd0) begin errors++; $display("FAIL midreset_wreg: got %0d expected 0", WriteRegister); end
      step();
      Rst_n = 1'b1;
      step();
      for (int i = 0; i < 2; i++) begin
         checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL postreset_regwrite: got %b expected 0", RegWrite); end
         checks++; if (RetireCount !== 32'd0) begin errors++; $display("FAIL postreset_count: got %0d expected 0", RetireCount); end
         step();
      end
   endtask

   task automatic test_alu_writeback();
      apply_reset();
      drive_instr(1'b1, 1'b1, 2'd0, 3'd0, 32'h1234_5678, 32'h0, 32'h0, 5'd7);
      step();
      drive_idle();
      #1;
      checks++; if (RegWrite !== 1'b1) begin errors++; $display("FAIL alu_regwrite: got %b expected 1", RegWrite); end
      checks++; if (WriteRegister !== 5'd7) begin errors++; $display("FAIL alu_wreg: got %0d expected 7", WriteRegister); end
      checks++; if (WriteData !== 32'h1234_5678) begin errors++; $display("FAIL alu_wdata: got %h expected 12345678", WriteData); end
      step();
      checks++; if (RetireCount !== 32'd1) begin errors++; $display("FAIL alu_count: got %0d expected 1", RetireCount); end
      checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL alu_no_repeat: got %b expected 0", RegWrite); end
   endtask

   task automatic test_load_extend();
      logic [2:0]  ltTab  [7] = '{3'd3, 3'd4, 3'd1, 3'd2, 3'd0, 3'd3, 3'd2};
      logic [1:0]  offTab [7] = '{2'd3, 2'd1, 2'd2, 2'd0, 2'd0, 2'd2, 2'd2};
      logic [31:0] expTab [7] = '{32'hFFFF_FF80, 32'h0000_007F, 32'hFFFF_80FF, 32'h0000_7F01,
                                  32'h80FF_7F01, 32'hFFFF_FFFF, 32'h0000_80FF};
      for (int i = 0; i < 7; i++) begin
         drive_instr(1'b1, 1'b1, 2'd1, ltTab[i], {30'h400, offTab[i]}, 32'h80FF_7F01, 32'h0, 5'd9);
         step();
         drive_idle();
         #1;
         checks++; if (WriteData !== expTab[i]) begin errors++; $display("FAIL load_ext[%0d]: got %h expected %h", i, WriteData, expTab[i]); end
         checks++; if (RegWrite !== 1'b1) begin errors++; $display("FAIL load_ext_we[%0d]: got %b expected 1", i, RegWrite); end
      end
      step();
   endtask

   task automatic test_r0_misalign();
      apply_reset();
      drive_instr(1'b1, 1'b1, 2'd0, 3'd0, 32'hCAFE_0000, 32'h0, 32'h0, 5'd0);
      step();
      drive_idle();
      #1;
      checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL r0_regwrite: got %b expected 0", RegWrite); end
      step();
      checks++; if (RetireCount !== 32'd1) begin errors++; $display("FAIL r0_count: got %0d expected 1", RetireCount); end
      // lw at 0x1002
      drive_instr(1'b1, 1'b1, 2'd1, 3'd0, 32'h0000_1002, 32'h1111_2222, 32'h0, 5'd4);
      step();
      drive_idle();
      #1;
      checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL mis_lw_regwrite: got %b expected 0", RegWrite); end
      checks++; if (MisalignErr !== 1'b1) begin errors++; $display("FAIL mis_lw_pulse: got %b expected 1", MisalignErr); end
      step();
      checks++; if (MisalignErr !== 1'b0) begin errors++; $display("FAIL mis_lw_pulse_end: got %b expected 0", MisalignErr); end
      checks++; if (RetireCount !== 32'd2) begin errors++; $display("FAIL mis_lw_count: got %0d expected 2", RetireCount); end
      // lh at odd address, held by a stall: pulse must not repeat
      drive_instr(1'b1, 1'b1, 2'd1, 3'd1, 32'h0000_2001, 32'h1111_2222, 32'h0, 5'd6);
      step();
      drive_idle();
      Stall = 1'b1;
      #1;
      checks++; if (MisalignErr !== 1'b1) begin errors++; $display("FAIL mis_lh_pulse: got %b expected 1", MisalignErr); end
      step();
      checks++; if (MisalignErr !== 1'b0) begin errors++; $display("FAIL mis_lh_stall: got %b expected 0", MisalignErr); end
      Stall = 1'b0;
      #1;
      checks++; if (MisalignErr !== 1'b0) begin errors++; $display("FAIL mis_lh_release: got %b expected 0", MisalignErr); end
      checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL mis_lh_regwrite: got %b expected 0", RegWrite); end
      step();
      checks++; if (RetireCount !== 32'd3) begin errors++; $display("FAIL mis_lh_count: got %0d expected 3", RetireCount); end
   endtask

   task automatic test_stall_flush();
      apply_reset();
      drive_instr(1'b1, 1'b1, 2'd2, 3'd0, 32'h0000_ABCD, 32'h0, 32'h0040_0010, 5'd31);
      step();
      drive_idle();
      Stall = 1'b1;
      #1;
      for (int i = 0; i < 3; i++) begin
         checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL stall_regwrite[%0d]: got %b expected 0", i, RegWrite); end
         checks++; if (WriteRegister !== 5'd31) begin errors++; $display("FAIL stall_wreg[%0d]: got %0d expected 31", i, WriteRegister); end
         if (i < 2) step();
      end
      Stall = 1'b0;
      #1;
      checks++; if (RegWrite !== 1'b1) begin errors++; $display("FAIL release_regwrite: got %b expected 1", RegWrite); end
      checks++; if (WriteData !== 32'h0040_0010) begin errors++; $display("FAIL release_wdata: got %h expected 00400010", WriteData); end
      checks++; if (RetireCount !== 32'd0) begin errors++; $display("FAIL release_count: got %0d expected 0", RetireCount); end
      step();
      checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL release_once: got %b expected 0", RegWrite); end
      checks++; if (RetireCount !== 32'd1) begin errors++; $display("FAIL release_count2: got %0d expected 1", RetireCount); end
      // Stall and Flush together
      drive_instr(1'b1, 1'b1, 2'd0, 3'd0, 32'h0000_0055, 32'h0, 32'h0, 5'd3);
      step();
      drive_idle();
      Stall = 1'b1;
      Flush = 1'b1;
      #1;
      checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL sf_regwrite: got %b expected 0", RegWrite); end
      step();
      Stall = 1'b0;
      Flush = 1'b0;
      #1;
      checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL sf_bubble_we: got %b expected 0", RegWrite); end
      checks++; if (WriteRegister !== 5'd0) begin errors++; $display("FAIL sf_bubble_wreg: got %0d expected 0", WriteRegister); end
      checks++; if (RetireCount !== 32'd1) begin errors++; $display("FAIL sf_count: got %0d expected 1", RetireCount); end
      step();
      checks++; if (RetireCount !== 32'd1) begin errors++; $display("FAIL sf_count2: got %0d expected 1", RetireCount); end
   endtask

   task automatic test_random();
      logic        eRw;
      logic        eFwd;
      logic [4:0]  eReg;
      logic [31:0] eData;
      logic        eMis;
      apply_reset();
      for (int n = 0; n < 400; n++) begin
         drive_instr($urandom_range(0, 9) < 8, $urandom_range(0, 7) != 0,
                     2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                     $urandom, $urandom, $urandom, 5'($urandom_range(0, 31)));
         Stall = $urandom_range(0, 4) == 0;
         Flush = $urandom_range(0, 9) == 0;
         #1;
         model_out(eRw, eFwd, eReg, eData, eMis);
         checks++; if (RegWrite !== eRw) begin errors++; $display("FAIL rnd_regwrite[%0d]: got %b expected %b", n, RegWrite, eRw); end
         checks++; if (WriteRegister !== eReg) begin errors++; $display("FAIL rnd_wreg[%0d]: got %0d expected %0d", n, WriteRegister, eReg); end
         checks++; if (MisalignErr !== eMis) begin errors++; $display("FAIL rnd_mis[%0d]: got %b expected %b", n, MisalignErr, eMis); end
         checks++; if (RetireCount !== mCount) begin errors++; $display("FAIL rnd_count[%0d]: got %0d expected %0d", n, RetireCount, mCount); end
         if (m.valid) begin
            checks++; if (WriteData !== eData) begin errors++; $display("FAIL rnd_wdata[%0d]: got %h expected %h", n, WriteData, eData); end
         end
`ifdef MEM_WB_FWD_EN
         checks++; if (FwdValid !== eFwd) begin errors++; $display("FAIL rnd_fwdvalid[%0d]: got %b expected %b", n, FwdValid, eFwd); end
`endif
         step();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      Rst_n = 1'b0;
      drive_idle();
      model_reset();
      test_reset();
      test_alu_writeback();
      test_load_extend();
      test_r0_misalign();
      test_stall_flush();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
